mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_pkg.sv | 9 +
 rtl/mem_wb_reg.sv | 51 +++++
 rtl/mem_stage.sv | 109 ++++++++++
 tb/tb_mem_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared state type and widths for the MEM pipeline stage
//   IDLE/WAIT load FSM states, SRAM word-address, data, PC and register-address widths
package mem_pkg;
    typedef enum logic {IDLE, WAIT} state_t;
    localparam int SRAM_AW = 12;
    localparam int DATA_W  = 32;
    localparam int PC_W    = 16;
    localparam int REG_AW  = 5;
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with load/bubble control
//   clk, rst_n        : clock, synchronous active-low reset (clears every field)
//   load_i            : 1 captures all *_i fields, 0 inserts a bubble (regwrite cleared, rest held)
//   regwrite_i .. pc_i: fields from the MEM stage
//   regwrite_o .. pc_o: registered write-back fields
module mem_wb_reg
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              regwrite_i,
    input  logic              memtoreg_i,
    input  logic [REG_AW-1:0] write_addr_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              regwrite_o,
    output logic              memtoreg_o,
    output logic [REG_AW-1:0] write_addr_o,
    output logic [DATA_W-1:0] result_o,
    output logic [PC_W-1:0]   pc_o
);
    logic              regwrite_q, memtoreg_q;
    logic [REG_AW-1:0] write_addr_q;
    logic [DATA_W-1:0] result_q;
    logic [PC_W-1:0]   pc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            write_addr_q <= '0;
            result_q     <= '0;
            pc_q         <= '0;
        end else if (load_i) begin
            regwrite_q   <= regwrite_i;
            memtoreg_q   <= memtoreg_i;
            write_addr_q <= write_addr_i;
            result_q     <= result_i;
            pc_q         <= pc_i;
        end else begin
            regwrite_q   <= 1'b0;
        end
    end

    assign regwrite_o   = regwrite_q;
    assign memtoreg_o   = memtoreg_q;
    assign write_addr_o = write_addr_q;
    assign result_o     = result_q;
    assign pc_o         = pc_q;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage driving a fixed-latency data SRAM, with load stall FSM
//   SRAM_LAT          : SRAM read latency, 1..3 cycles
//   clk, rst_n        : clock, synchronous active-low reset
//   ex_*_i            : EX/MEM slot contents (memread_n/memwrite_n active-low)
//   sram_*            : SRAM chip/write enable (active-low), word address, write/read data
//   stall_o           : holds EX/MEM while a load waits for SRAM data
//   pc_src_o, branch_target_o : taken-branch redirect
//   wb_*_o            : registered MEM/WB outputs
module mem_stage
    import mem_pkg::*;
#(
    parameter int SRAM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid_i,
    input  logic [PC_W-1:0]    ex_pc_i,
    input  logic               ex_regwrite_i,
    input  logic [DATA_W-1:0]  ex_alu_result_i,
    input  logic [DATA_W-1:0]  ex_write_data_i,
    input  logic [REG_AW-1:0]  ex_write_addr_i,
    input  logic               ex_memread_n_i,
    input  logic               ex_memwrite_n_i,
    input  logic               ex_memtoreg_i,
    input  logic               ex_branch_i,
    input  logic               ex_zero_i,
    output logic               sram_cen_o,
    output logic               sram_wen_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [DATA_W-1:0]  sram_d_o,
    input  logic [DATA_W-1:0]  sram_q_i,
    output logic               stall_o,
    output logic               pc_src_o,
    output logic [PC_W-1:0]    branch_target_o,
    output logic               wb_regwrite_o,
    output logic               wb_memtoreg_o,
    output logic [REG_AW-1:0]  wb_write_addr_o,
    output logic [DATA_W-1:0]  wb_result_o,
    output logic [PC_W-1:0]    wb_pc_o
);
    localparam logic [1:0] LAT = 2'(SRAM_LAT);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       is_store, is_load, done, stall, cen, wen;

    // a simultaneous read+write request is treated as a store
    assign is_store = ex_valid_i & ~ex_memwrite_n_i;
    assign is_load  = ex_valid_i & ~ex_memread_n_i & ex_memwrite_n_i;
    assign done     = (state_q == WAIT) && (cnt_q == LAT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        cen     = 1'b1;
        wen     = 1'b1;
        if (state_q == IDLE) begin
            cen   = ~(is_store | is_load);
            wen   = ~is_store;
            stall = is_load;
            if (is_load) begin
                state_d = WAIT;
                cnt_d   = 2'd1;
            end
        end else if (cnt_q == LAT) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            stall = 1'b1;
            cnt_d = cnt_q + 2'd1;
        end
    end

    // control outputs are forced idle while reset is held
    assign sram_cen_o      = cen | ~rst_n;
    assign sram_wen_o      = wen | ~rst_n;
    assign stall_o         = stall & rst_n;
    assign pc_src_o        = rst_n & (state_q == IDLE) & ex_valid_i & ex_branch_i & ex_zero_i;
    assign sram_addr_o     = ex_alu_result_i[SRAM_AW+1:2];
    assign sram_d_o        = ex_write_data_i;
    assign branch_target_o = ex_pc_i;

    mem_wb_reg u_mem_wb (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (ex_valid_i & ~stall),
        .regwrite_i   (ex_regwrite_i),
        .memtoreg_i   (ex_memtoreg_i),
        .write_addr_i (ex_write_addr_i),
        .result_i     (done ? sram_q_i : ex_alu_result_i),
        .pc_i         (ex_pc_i),
        .regwrite_o   (wb_regwrite_o),
        .memtoreg_o   (wb_memtoreg_o),
        .write_addr_o (wb_write_addr_o),
        .result_o     (wb_result_o),
        .pc_o         (wb_pc_o)
    );
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage at SRAM_LAT=1 and SRAM_LAT=3
module tb_mem_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        memtoreg;
        logic [4:0]  waddr;
        logic [31:0] result;
        logic [15:0] pc;
    } wb_t;

    task automatic check(input int lat, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL L%0d %s: got %h, expected %h", lat, nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_lat
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        rst_n, ex_valid, ex_regwrite, ex_memread_n, ex_memwrite_n;
        logic        ex_memtoreg, ex_branch, ex_zero;
        logic [15:0] ex_pc;
        logic [31:0] ex_alu, ex_wdata;
        logic [4:0]  ex_waddr;
        logic        cen, wen, stall, pc_src, wb_regwrite, wb_memtoreg;
        logic [11:0] addr;
        logic [31:0] sram_d, sram_q, wb_result;
        logic [15:0] branch_target, wb_pc;
        logic [4:0]  wb_waddr;
        logic [31:0] sram_mem [4096];
        logic [31:0] ref_mem [4096];
        logic [31:0] pipe_d [4];
        logic [3:0]  pipe_v;
        int          n_ce = 0;
        wb_t         exp_q [$];
        logic        done = 1'b0;

        mem_stage #(.SRAM_LAT(LAT)) dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .ex_valid_i      (ex_valid),
            .ex_pc_i         (ex_pc),
            .ex_regwrite_i   (ex_regwrite),
            .ex_alu_result_i (ex_alu),
            .ex_write_data_i (ex_wdata),
            .ex_write_addr_i (ex_waddr),
            .ex_memread_n_i  (ex_memread_n),
            .ex_memwrite_n_i (ex_memwrite_n),
            .ex_memtoreg_i   (ex_memtoreg),
            .ex_branch_i     (ex_branch),
            .ex_zero_i       (ex_zero),
            .sram_cen_o      (cen),
            .sram_wen_o      (wen),
            .sram_addr_o     (addr),
            .sram_d_o        (sram_d),
            .sram_q_i        (sram_q),
            .stall_o         (stall),
            .pc_src_o        (pc_src),
            .branch_target_o (branch_target),
            .wb_regwrite_o   (wb_regwrite),
            .wb_memtoreg_o   (wb_memtoreg),
            .wb_write_addr_o (wb_waddr),
            .wb_result_o     (wb_result),
            .wb_pc_o         (wb_pc)
        );

        // behavioural SRAM: data appears exactly LAT cycles after the enable cycle, garbage otherwise
        always @(posedge clk) begin
            if (!cen && !wen) sram_mem[addr] <= sram_d;
            if (!cen) n_ce <= n_ce + 1;
            pipe_v    <= {pipe_v[2:0], !cen && wen};
            pipe_d[0] <= sram_mem[addr];
            for (int i = 1; i < 4; i++) pipe_d[i] <= pipe_d[i-1];
        end
        assign sram_q = pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'hBAD0_BAD0;

        always @(negedge clk) begin
            wb_t e;
            if (wb_regwrite === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL L%0d wb_unexpected: got write-back r%0d=%h, expected none", LAT, wb_waddr, wb_result);
                end else begin
                    e = exp_q.pop_front();
                    check(LAT, "wb_result", wb_result, e.result);
                    check(LAT, "wb_write_addr", wb_waddr, e.waddr);
                    check(LAT, "wb_memtoreg", wb_memtoreg, e.memtoreg);
                    check(LAT, "wb_pc", wb_pc, e.pc);
                end
            end
        end

        task automatic drive(input logic v, rn, wn, rw, mtr, br, z, input logic [15:0] pc,
                             input logic [31:0] alu, wd, input logic [4:0] wa);
            ex_valid = v; ex_memread_n = rn; ex_memwrite_n = wn; ex_regwrite = rw;
            ex_memtoreg = mtr; ex_branch = br; ex_zero = z; ex_pc = pc;
            ex_alu = alu; ex_wdata = wd; ex_waddr = wa;
        endtask

        task automatic issue(input logic v, rn, wn, rw, mtr, br, z, input logic [15:0] pc,
                             input logic [31:0] alu, wd, input logic [4:0] wa);
            int   stalls = 0;
            logic ld = v && !rn && wn;
            logic st = v && !wn;
            drive(v, rn, wn, rw, mtr, br, z, pc, alu, wd, wa);
            if (st) ref_mem[alu[13:2]] = wd;
            if (v && rw) exp_q.push_back('{mtr, wa, ld ? ref_mem[alu[13:2]] : alu, pc});
            @(negedge clk);
            check(LAT, "cen", cen, !(ld || st));
            check(LAT, "wen", wen, !st);
            check(LAT, "addr", addr, alu[13:2]);
            check(LAT, "sram_d", sram_d, wd);
            check(LAT, "pc_src", pc_src, v && br && z);
            check(LAT, "branch_target", branch_target, pc);
            while (stall === 1'b1 && stalls < 8) begin
                stalls++;
                @(negedge clk);
                check(LAT, "wait_cen", cen, 1);
                check(LAT, "wait_pc_src", pc_src, 0);
            end
            check(LAT, "stall_cycles", stalls, ld ? LAT : 0);
            @(posedge clk);
            #1;
        endtask

        initial begin
            time         t0;
            int          ce0;
            logic [31:0] r, a;
            for (int i = 0; i < 4096; i++) begin
                sram_mem[i] = $urandom;
                ref_mem[i]  = sram_mem[i];
            end
            rst_n = 1'b0;
            drive(1, 0, 0, 1, 1, 1, 1, 16'hFFFF, 32'hFFFF_FFFF, 32'h1, 5'd31);
            repeat (2) @(posedge clk);
            #1;
            check(LAT, "rst_cen", cen, 1);
            check(LAT, "rst_wen", wen, 1);
            check(LAT, "rst_stall", stall, 0);
            check(LAT, "rst_pc_src", pc_src, 0);
            check(LAT, "rst_wb_regwrite", wb_regwrite, 0);
            check(LAT, "rst_wb_memtoreg", wb_memtoreg, 0);
            check(LAT, "rst_wb_result", wb_result, 0);
            check(LAT, "rst_wb_addr", wb_waddr, 0);
            check(LAT, "rst_wb_pc", wb_pc, 0);
            rst_n = 1'b1;
            issue(1, 1, 0, 0, 0, 0, 0, 16'h0100, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0);
            issue(1, 0, 1, 1, 1, 0, 0, 16'h0104, 32'h0000_0010, 32'h0, 5'd3);
            issue(1, 1, 1, 0, 0, 1, 1, 16'h0040, 32'h0, 32'h0, 5'd0);
            issue(1, 1, 1, 0, 0, 1, 0, 16'h0040, 32'h0, 32'h0, 5'd0);
            issue(1, 0, 0, 1, 0, 0, 0, 16'h0108, 32'hC000_0023, 32'h1234_5678, 5'd7);
            issue(1, 0, 1, 1, 1, 0, 0, 16'h010C, 32'h0000_0020, 32'h0, 5'd8);
            issue(1, 1, 1, 1, 0, 0, 0, 16'h0110, 32'hCAFE_F00D, 32'h0, 5'd9);
            t0  = $time;
            ce0 = n_ce;
            issue(1, 0, 1, 1, 1, 0, 0, 16'h0114, 32'h0000_0010, 32'h0, 5'd10);
            issue(1, 0, 1, 1, 1, 0, 0, 16'h0118, 32'h0000_0020, 32'h0, 5'd11);
            check(LAT, "b2b_cycles", 32'(($time - t0) / 10), 2 * (LAT + 1));
            check(LAT, "b2b_cen_pulses", n_ce - ce0, 2);
            issue(0, 0, 1, 1, 0, 1, 1, 16'h011C, 32'h0000_0030, 32'h0, 5'd12);
            drive(1, 0, 1, 1, 1, 0, 0, 16'h0200, 32'h0000_0044, 32'h0, 5'd13);
            @(posedge clk);
            repeat (LAT > 1 ? 1 : 0) @(posedge clk);
            #1;
            rst_n = 1'b0;
            @(negedge clk);
            check(LAT, "abort_cen", cen, 1);
            check(LAT, "abort_stall", stall, 0);
            @(posedge clk);
            #1;
            check(LAT, "abort_wb_regwrite", wb_regwrite, 0);
            rst_n    = 1'b1;
            ex_valid = 1'b0;
            repeat (LAT + 2) @(posedge clk);
            #1;
            for (int k = 0; k < 80; k++) begin
                r = $urandom;
                a = $urandom & 32'hFFFF_C03F;
                issue(r[2:0] != 0, r[3], r[4] | r[5], r[6], r[7], r[8], r[9], r[31:16], a, $urandom, r[14:10]);
            end
            ex_valid = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            check(LAT, "drain_pending", exp_q.size(), 0);
            done = 1'b1;
        end
    end

    initial begin
        int cyc = 0;
        while (!(gen_lat[0].done && gen_lat[1].done) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 20000) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: got %0d cycles without completion, expected both runs done", cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
